dpram_stream_ctrl: RTL

// Initiator-side controller for the 64x8 true dual-port RAM: turns that RAM into a

---
 rtl/dpram_stream_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/dpram_stream_ctrl.sv
// Streaming FIFO controller around a 64x8 true dual-port RAM: port A writes, port B reads
// (1-cycle registered), 3-entry output buffer. Optional level port: DPRAM_CTRL_LEVEL_EN.
module dpram_stream_ctrl #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic          ram_we_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_b
`ifdef DPRAM_CTRL_LEVEL_EN
  ,
  output logic [AW+1:0] level
`endif
);

  localparam logic [AW:0] FullDiff = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wr_ptr_q, rd_ptr_q, used;
  logic          inflight_q, rst_done_q;
  logic          wr_en, rd_en, pop;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [DW-1:0] ob_q [3];
  logic [DW-1:0] ob_d [3];

  assign used    = wr_ptr_q - rd_ptr_q;
  assign s_ready = rst_done_q && (used != FullDiff);
  assign wr_en   = s_valid && s_ready;

  assign ram_we_a   = wr_en;
  assign ram_addr_a = wr_ptr_q[AW-1:0];
  assign ram_data_a = s_data;

  // Read issue looks only at registered state, so m_ready never reaches the RAM ports.
  assign rd_en      = (used != '0) && (({1'b0, ob_cnt_q} + {2'b00, inflight_q}) < 3'd3);
  assign ram_addr_b = rd_ptr_q[AW-1:0];
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

  assign m_valid = (ob_cnt_q != 2'd0);
  assign m_data  = ob_q[0];
  assign pop     = m_valid && m_ready;

`ifdef DPRAM_CTRL_LEVEL_EN
  assign level = {1'b0, used} + {{(AW+1){1'b0}}, inflight_q} + {{AW{1'b0}}, ob_cnt_q};
`endif

  // Pop shifts the buffer toward the head; the returning RAM word lands after the shift.
  always_comb begin
    ob_d     = ob_q;
    ob_cnt_d = ob_cnt_q;
    if (pop) begin
      ob_d[0]  = ob_q[1];
      ob_d[1]  = ob_q[2];
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      case (ob_cnt_d)
        2'd0:    ob_d[0] = ram_q_b;
        2'd1:    ob_d[1] = ram_q_b;
        default: ob_d[2] = ram_q_b;
      endcase
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      rst_done_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      for (int i = 0; i < 3; i++) ob_q[i] <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      inflight_q <= rd_en;
      ob_cnt_q   <= ob_cnt_d;
      ob_q       <= ob_d;
    end
  end

endmodule
